// File: rtl/axi_arb_pkg.sv
// Shared payload types, widths and FSM encoding for the AXI3 write-port arbiter.
package axi_arb_pkg;

  localparam int AW_W = 45;
  localparam int W_W  = 37;
  localparam int B_W  = 6;

  typedef logic [AW_W-1:0] aw_pld_t;
  typedef logic [W_W-1:0]  w_pld_t;
  typedef logic [B_W-1:0]  b_pld_t;

  typedef enum logic [1:0] {IDLE, AW, W} arb_state_t;

  function automatic logic [3:0] aw_id(input aw_pld_t p);
    return p[44:41];
  endfunction

endpackage

// File: rtl/axi_arb_order_fifo.sv
// Grant-order FIFO: remembers which master owns each outstanding burst so B can be routed back.
module axi_arb_order_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (int'(wr_ptr) == DEPTH-1) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (int'(rd_ptr) == DEPTH-1) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI3 write port; one burst in flight on AW/W, B routed by grant order.
//   state | meaning
//   IDLE  | waiting for a requester and a free order-FIFO slot
//   AW    | presenting the latched AW payload downstream
//   W     | W channel locked to the granted master until wlast
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int OUTS  = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [N_REQ-1:0]      s_awvalid,
  output logic [N_REQ-1:0]      s_awready,
  input  logic [N_REQ*AW_W-1:0] s_aw_pld,
  input  logic [N_REQ-1:0]      s_wvalid,
  output logic [N_REQ-1:0]      s_wready,
  input  logic [N_REQ*W_W-1:0]  s_w_pld,
  output logic [N_REQ-1:0]      s_bvalid,
  input  logic [N_REQ-1:0]      s_bready,
  output logic [B_W-1:0]        s_b_pld,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [AW_W-1:0]       m_aw_pld,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [W_W-1:0]        m_w_pld,
  output logic [3:0]            m_wid,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  input  logic [B_W-1:0]        m_b_pld
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       state;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_next;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;
  aw_pld_t          aw_q;
  aw_pld_t          aw_sel;
  w_pld_t           w_sel;
  logic             aw_vld;
  logic [3:0]       wid_q;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [IDX_W-1:0] fifo_head;
  logic             err_orphan_b;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_vld && s_awvalid[(int'(rr_ptr) + i) % N_REQ]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'((int'(rr_ptr) + i) % N_REQ);
      end
    end
  end

  assign aw_sel  = s_aw_pld[int'(pick_idx)*AW_W +: AW_W];
  assign w_sel   = s_w_pld[int'(grant)*W_W +: W_W];
  assign rr_next = (int'(grant) == N_REQ-1) ? '0 : grant + 1'b1;

  always_comb begin
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    m_wvalid  = 1'b0;
    m_w_pld   = '0;
    m_bready  = 1'b0;
    if (aw_vld) s_awready[grant] = m_awready;
    if (state == W) begin
      m_wvalid        = s_wvalid[grant];
      s_wready[grant] = m_wready;
      m_w_pld         = w_sel;
    end
    if (!fifo_empty) begin
      s_bvalid[fifo_head] = m_bvalid;
      m_bready            = s_bready[fifo_head];
    end
  end

  assign m_awvalid = aw_vld;
  assign m_aw_pld  = aw_q;
  assign m_wid     = wid_q;
  assign s_b_pld   = m_b_pld;
  assign fifo_push = aw_vld & m_awready;
  assign fifo_pop  = m_bvalid & m_bready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      aw_q   <= '0;
      aw_vld <= 1'b0;
      wid_q  <= '0;
    end else begin
      case (state)
        IDLE: if (pick_vld && !fifo_full) begin
          grant  <= pick_idx;
          aw_q   <= aw_sel;
          wid_q  <= aw_id(aw_sel);
          aw_vld <= 1'b1;
          state  <= AW;
        end
        AW: if (m_awready) begin
          aw_vld <= 1'b0;
          rr_ptr <= rr_next;
          state  <= W;
        end
        W: if (m_wvalid && m_wready && w_sel[0]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  axi_arb_order_fifo #(.WIDTH(IDX_W), .DEPTH(OUTS)) u_order_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .wdata  (grant),
    .pop    (fifo_pop),
    .rdata  (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // a B with no outstanding burst has no owner; it is left unacknowledged
  assign err_orphan_b = m_bvalid & fifo_empty;

  a_orphan_b: assert property (@(posedge clk) disable iff (!resetn) !err_orphan_b);

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Randomized bench: master/slave models plus a round-robin order model checked against the arbiter.
module tb_axi_wr_arbiter;
  import axi_arb_pkg::*;

  localparam int N    = 2;
  localparam int OUTS = 4;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [N-1:0]      s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [N*AW_W-1:0] s_aw_pld;
  logic [N*W_W-1:0]  s_w_pld;
  b_pld_t            s_b_pld;
  logic              m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  aw_pld_t           m_aw_pld;
  w_pld_t            m_w_pld;
  logic [3:0]        m_wid;
  b_pld_t            m_b_pld;

  always #5 clk = ~clk;

  axi_wr_arbiter #(.N_REQ(N), .OUTS(OUTS)) dut (
    .clk(clk), .resetn(resetn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_aw_pld(s_aw_pld),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_w_pld(s_w_pld),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_b_pld(s_b_pld),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_aw_pld(m_aw_pld),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_w_pld(m_w_pld), .m_wid(m_wid),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_b_pld(m_b_pld)
  );

  typedef struct packed {
    logic [1:0]        mst;
    logic [3:0]        id;
    logic [3:0]        len;
    logic [31:0]       addr;
    logic [15:0][35:0] beats;
  } burst_t;

  burst_t      bursts[$];
  int          mq_aw[N][$];
  int          mq_w[N][$];
  int          wbeat[N];
  int          grant_seen[$];
  aw_pld_t     maw_seen[$];
  logic [40:0] mw_seen[$];
  b_pld_t      b_seen[N][$];
  int          maw_cyc[$], wlast_cyc[$], bpop_cyc[$];
  logic [3:0]  saq_id[$];
  logic [31:0] saq_addr[$];
  b_pld_t      sbq[$];
  int          exp_order[$];
  bit          aw_en[N];
  int          w_gap[N];
  int          br_gap, awr_gap, wr_gap, bv_gap, aw_hold;
  bit          b_hold, w_open, prev_stall;
  aw_pld_t     prev_aw;
  int          cyc, first_awv, prot_viol;
  int          n_vec = 0, n_err = 0;

  function automatic aw_pld_t mk_aw(input burst_t b);
    return {b.id, b.len, 3'b010, b.addr, 2'b01};
  endfunction

  function automatic b_pld_t mk_b(input logic [3:0] id, input logic [31:0] addr);
    return {id, addr[5:4]};
  endfunction

  task automatic clear_tb();
    bursts.delete(); grant_seen.delete(); maw_seen.delete(); mw_seen.delete();
    maw_cyc.delete(); wlast_cyc.delete(); bpop_cyc.delete();
    saq_id.delete(); saq_addr.delete(); sbq.delete();
    for (int m = 0; m < N; m++) begin
      mq_aw[m].delete(); mq_w[m].delete(); b_seen[m].delete();
      wbeat[m] = 0; aw_en[m] = 1'b1; w_gap[m] = 0;
    end
    br_gap = 0; awr_gap = 0; wr_gap = 0; bv_gap = 0; aw_hold = 0;
    b_hold = 0; w_open = 0; prev_stall = 0; prev_aw = '0;
    first_awv = -1; prot_viol = 0;
    s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_aw_pld = '0; s_w_pld = '0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_b_pld = '0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_tb();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic new_burst(input int m, input logic [3:0] id, input logic [3:0] len,
                           input logic [31:0] addr);
    burst_t b;
    b.mst = 2'(m); b.id = id; b.len = len; b.addr = addr;
    for (int k = 0; k < 16; k++) b.beats[k] = {$urandom(), 4'($urandom_range(15))};
    bursts.push_back(b);
    mq_aw[m].push_back(bursts.size() - 1);
    mq_w[m].push_back(bursts.size() - 1);
  endtask

  // one clock: drive at posedge+1, observe handshakes at negedge
  task automatic step();
    logic [3:0]  id;
    logic [31:0] ad;
    for (int m = 0; m < N; m++) begin
      s_awvalid[m] = aw_en[m] && mq_aw[m].size() > 0;
      if (mq_aw[m].size() > 0) s_aw_pld[m*AW_W +: AW_W] = mk_aw(bursts[mq_aw[m][0]]);
      s_wvalid[m] = mq_w[m].size() > 0 && int'($urandom_range(99)) >= w_gap[m];
      if (mq_w[m].size() > 0) begin
        burst_t b;
        b = bursts[mq_w[m][0]];
        s_w_pld[m*W_W +: W_W] = {b.beats[wbeat[m]], wbeat[m] == int'(b.len)};
      end
      s_bready[m] = int'($urandom_range(99)) >= br_gap;
    end
    m_awready = aw_hold == 0 && int'($urandom_range(99)) >= awr_gap;
    m_wready  = int'($urandom_range(99)) >= wr_gap;
    m_bvalid  = !b_hold && sbq.size() > 0 && int'($urandom_range(99)) >= bv_gap;
    m_b_pld   = (sbq.size() > 0) ? sbq[0] : '0;
    @(negedge clk);
    for (int m = 0; m < N; m++) begin
      if (s_awvalid[m] && s_awready[m]) grant_seen.push_back(mq_aw[m].pop_front());
      if (s_wvalid[m] && s_wready[m]) begin
        if (wbeat[m] == int'(bursts[mq_w[m][0]].len)) begin
          void'(mq_w[m].pop_front());
          wbeat[m] = 0;
        end else wbeat[m]++;
      end
      if (s_bvalid[m] && s_bready[m]) b_seen[m].push_back(s_b_pld);
    end
    if (m_awvalid && first_awv < 0) first_awv = cyc;
    if (m_awvalid && !m_awready && |s_awready) prot_viol++;
    if (prev_stall && (!m_awvalid || m_aw_pld !== prev_aw)) prot_viol++;
    prev_stall = m_awvalid && !m_awready;
    prev_aw    = m_aw_pld;
    if (m_awvalid && m_awready) begin
      if (w_open) prot_viol++;
      w_open = 1'b1;
      maw_seen.push_back(m_aw_pld);
      maw_cyc.push_back(cyc);
      saq_id.push_back(m_aw_pld[44:41]);
      saq_addr.push_back(m_aw_pld[33:2]);
    end
    if (m_wvalid && m_wready) begin
      mw_seen.push_back({m_wid, m_w_pld});
      if (m_w_pld[0]) begin
        w_open = 1'b0;
        wlast_cyc.push_back(cyc);
        if (saq_id.size() == 0) prot_viol++;
        else begin
          id = saq_id.pop_front();
          ad = saq_addr.pop_front();
          sbq.push_back(mk_b(id, ad));
        end
      end
    end
    if (m_bvalid && m_bready) begin
      void'(sbq.pop_front());
      bpop_cyc.push_back(cyc);
    end
    if (m_awvalid && aw_hold > 0) aw_hold--;
    @(posedge clk);
    #1 cyc++;
  endtask

  function automatic bit busy();
    busy = (saq_id.size() > 0) || (sbq.size() > 0);
    for (int m = 0; m < N; m++)
      if (mq_aw[m].size() > 0 || mq_w[m].size() > 0) busy = 1'b1;
  endfunction

  task automatic run_drain(input int budget, output bit to);
    int k;
    k = 0;
    while (busy() && k < budget) begin
      step();
      k++;
    end
    to = busy();
  endtask

  // round robin over masters still holding bursts, pointer moves past each winner
  task automatic model_order();
    int lst[N][$];
    int ptr, left;
    exp_order.delete();
    foreach (bursts[i]) lst[bursts[i].mst].push_back(i);
    ptr  = 0;
    left = bursts.size();
    while (left > 0) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (ptr + i) % N;
        if (lst[k].size() > 0) begin
          exp_order.push_back(lst[k].pop_front());
          ptr = (k + 1) % N;
          left--;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    s_awvalid = '1; s_bready = '1; s_wvalid = '1;
    m_awready = 1; m_wready = 1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid} !== '0) begin
      n_err++;
      $display("FAIL reset_valids got=%b want=0",
               {m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid});
    end
    n_vec++;
    if ({m_wid, m_aw_pld} !== '0) begin
      n_err++;
      $display("FAIL reset_payload got=%h want=0", {m_wid, m_aw_pld});
    end
    do_reset();
  endtask

  task automatic test_single();
    bit to;
    int req_cyc;
    do_reset();
    new_burst(0, 4'h5, 4'd3, 32'h100);
    req_cyc = cyc;
    run_drain(200, to);
    n_vec++;
    if (to || maw_seen.size() != 1 || mw_seen.size() != 4) begin
      n_err++;
      $display("FAIL single_counts to=%0d aw=%0d w=%0d want 0/1/4", to, maw_seen.size(), mw_seen.size());
    end else begin
      n_vec++;
      if (maw_seen[0] !== mk_aw(bursts[0])) begin
        n_err++;
        $display("FAIL single_aw got=%h want=%h", maw_seen[0], mk_aw(bursts[0]));
      end
      for (int k = 0; k < 4; k++) begin
        n_vec++;
        if (mw_seen[k] !== {4'h5, bursts[0].beats[k], k == 3}) begin
          n_err++;
          $display("FAIL single_w%0d got=%h want=%h", k, mw_seen[k], {4'h5, bursts[0].beats[k], k == 3});
        end
      end
    end
    n_vec++;
    if (first_awv - req_cyc != 1) begin
      n_err++;
      $display("FAIL single_latency got=%0d want=1", first_awv - req_cyc);
    end
    n_vec++;
    if (b_seen[0].size() != 1 || b_seen[1].size() != 0 || b_seen[0][0] !== 6'h14) begin
      n_err++;
      $display("FAIL single_b got m0=%0d m1=%0d want m0=1 bpld=14 m1=0", b_seen[0].size(), b_seen[1].size());
    end
  endtask

  task automatic test_round_robin();
    bit to;
    do_reset();
    for (int j = 0; j < 4; j++)
      for (int m = 0; m < N; m++)
        new_burst(m, 4'($urandom_range(15)), 4'($urandom_range(3)), $urandom());
    awr_gap = 30; wr_gap = 30; br_gap = 20;
    run_drain(1000, to);
    model_order();
    n_vec++;
    if (to || grant_seen.size() != 8) begin
      n_err++;
      $display("FAIL rr_count to=%0d got=%0d want=8", to, grant_seen.size());
    end else
      for (int k = 0; k < 8; k++) begin
        n_vec++;
        if (bursts[grant_seen[k]].mst !== 2'(k % 2) || grant_seen[k] != exp_order[k]) begin
          n_err++;
          $display("FAIL rr_grant%0d got=%0d want=%0d", k, grant_seen[k], exp_order[k]);
        end
      end
  endtask

  task automatic test_aw_stall();
    bit to;
    do_reset();
    aw_hold = 5;
    new_burst(1, 4'hA, 4'd1, 32'h2000);
    run_drain(200, to);
    n_vec++;
    if (to || maw_cyc.size() != 1 || maw_cyc[0] - first_awv != 5) begin
      n_err++;
      $display("FAIL aw_stall_accept to=%0d n=%0d want accept 5 cycles after m_awvalid", to, maw_cyc.size());
    end
    n_vec++;
    if (prot_viol != 0 || grant_seen.size() != 1) begin
      n_err++;
      $display("FAIL aw_stall_protocol viol=%0d grants=%0d want 0/1", prot_viol, grant_seen.size());
    end
  endtask

  task automatic test_fifo_full();
    bit to;
    do_reset();
    b_hold = 1;
    for (int j = 0; j < 5; j++) new_burst(0, 4'(j), 4'd0, 32'(j * 16));
    repeat (40) step();
    n_vec++;
    if (maw_seen.size() != 4 || mq_aw[0].size() != 1) begin
      n_err++;
      $display("FAIL full_block got aw=%0d pending=%0d want 4/1", maw_seen.size(), mq_aw[0].size());
    end
    b_hold = 0;
    run_drain(200, to);
    n_vec++;
    if (to || maw_seen.size() != 5 || bpop_cyc.size() == 0 || maw_cyc[4] <= bpop_cyc[0]) begin
      n_err++;
      $display("FAIL full_release to=%0d aw=%0d want 5th AW after first B pop", to, maw_seen.size());
    end
    n_vec++;
    if (b_seen[0].size() != 5) begin
      n_err++;
      $display("FAIL full_b got=%0d want=5", b_seen[0].size());
    end
  endtask

  task automatic test_w_stall();
    bit to;
    int k;
    do_reset();
    aw_en[0] = 0;
    w_gap[1] = 60;
    new_burst(1, 4'h3, 4'd5, 32'h40);
    new_burst(0, 4'h9, 4'd1, 32'h80);
    k = 0;
    while (grant_seen.size() == 0 && k < 50) begin
      step();
      k++;
    end
    aw_en[0] = 1;
    run_drain(500, to);
    n_vec++;
    if (to || maw_seen.size() != 2 || wlast_cyc.size() != 2) begin
      n_err++;
      $display("FAIL wstall_count to=%0d aw=%0d want 2", to, maw_seen.size());
    end else begin
      n_vec++;
      if (maw_seen[1][44:41] !== 4'h9 || maw_cyc[1] <= wlast_cyc[0]) begin
        n_err++;
        $display("FAIL wstall_order id=%h aw_cyc=%0d wlast_cyc=%0d want id 9 after wlast",
                 maw_seen[1][44:41], maw_cyc[1], wlast_cyc[0]);
      end
    end
    n_vec++;
    if (mw_seen.size() != 8 || prot_viol != 0) begin
      n_err++;
      $display("FAIL wstall_beats got=%0d viol=%0d want 8/0", mw_seen.size(), prot_viol);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int k;
    do_reset();
    new_burst(0, 4'h1, 4'd3, 32'h10);
    k = 0;
    while (mw_seen.size() < 1 && k < 50) begin
      step();
      k++;
    end
    resetn = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if ({m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid, m_wid} !== '0 || k >= 50) begin
      n_err++;
      $display("FAIL midreset_outputs got=%b k=%0d want 0",
               {m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid}, k);
    end
    clear_tb();
    resetn = 1'b1;
    b_hold = 1;
    new_burst(1, 4'h2, 4'd0, 32'h20);
    new_burst(1, 4'h3, 4'd0, 32'h30);
    new_burst(0, 4'h4, 4'd0, 32'h40);
    new_burst(0, 4'h5, 4'd0, 32'h50);
    repeat (40) step();
    n_vec++;
    if (grant_seen.size() != 4 || bursts[grant_seen[0]].mst !== 2'd0) begin
      n_err++;
      $display("FAIL midreset_state grants=%0d want 4 with m0 first", grant_seen.size());
    end
    b_hold = 0;
    run_drain(200, to);
    n_vec++;
    if (to || b_seen[0].size() != 2 || b_seen[1].size() != 2) begin
      n_err++;
      $display("FAIL midreset_b to=%0d m0=%0d m1=%0d want 2/2", to, b_seen[0].size(), b_seen[1].size());
    end
  endtask

  task automatic test_random(input int iter);
    bit to;
    int wi;
    do_reset();
    for (int m = 0; m < N; m++) begin
      int cnt;
      cnt = int'($urandom_range(4, 1));
      for (int j = 0; j < cnt; j++)
        new_burst(m, 4'($urandom_range(15)), 4'($urandom_range(15)), $urandom());
      w_gap[m] = int'($urandom_range(50));
    end
    awr_gap = int'($urandom_range(50)); wr_gap = int'($urandom_range(50));
    br_gap  = int'($urandom_range(50)); bv_gap = int'($urandom_range(50));
    run_drain(4000, to);
    model_order();
    n_vec++;
    if (to || grant_seen.size() != exp_order.size() || maw_seen.size() != exp_order.size()) begin
      n_err++;
      $display("FAIL rand%0d_count to=%0d got=%0d want=%0d", iter, to, grant_seen.size(), exp_order.size());
      return;
    end
    wi = 0;
    foreach (exp_order[k]) begin
      burst_t b;
      b = bursts[exp_order[k]];
      n_vec++;
      if (grant_seen[k] != exp_order[k] || maw_seen[k] !== mk_aw(b)) begin
        n_err++;
        $display("FAIL rand%0d_aw%0d got=%h want=%h", iter, k, maw_seen[k], mk_aw(b));
      end
      for (int j = 0; j <= int'(b.len); j++) begin
        n_vec++;
        if (wi >= mw_seen.size() || mw_seen[wi] !== {b.id, b.beats[j], j == int'(b.len)}) begin
          n_err++;
          $display("FAIL rand%0d_w%0d want=%h", iter, wi, {b.id, b.beats[j], j == int'(b.len)});
        end
        wi++;
      end
    end
    for (int m = 0; m < N; m++) begin
      int bi;
      bi = 0;
      foreach (bursts[i]) if (int'(bursts[i].mst) == m) begin
        n_vec++;
        if (bi >= b_seen[m].size() || b_seen[m][bi] !== mk_b(bursts[i].id, bursts[i].addr)) begin
          n_err++;
          $display("FAIL rand%0d_b m%0d idx%0d want=%h", iter, m, bi, mk_b(bursts[i].id, bursts[i].addr));
        end
        bi++;
      end
    end
  endtask

  initial begin
    cyc = 0;
    clear_tb();
    test_reset();
    test_single();
    test_round_robin();
    test_aw_stall();
    test_fifo_full();
    test_w_stall();
    test_reset_mid();
    for (int i = 0; i < 3; i++) test_random(i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
